// File: rtl/simd_lane_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simd_lane_issue_ctrl
// Description : Issue-side controller for one SIMD lane: drives the lane
//               regfile ports and ALU op enables, captures the ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_lane_issue_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RD_LAT = 1,
    parameter bit          WB_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rs2,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_wr_en,
    output logic              rs1_rd_en,
    output logic              rs2_rd_en,
    output logic              Radd_en,
    output logic              Rsub_en,
    output logic              bitrev_en,
    output logic              mul_en,
    input  logic [DATA_W-1:0] aluresult_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_rd,
    output logic              illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_WR = 3'd1,
        S_EXEC    = 3'd2,
        S_WB      = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [2:0] c_op_nop    = 3'b000;
    localparam logic [2:0] c_op_load   = 3'b001;
    localparam logic [2:0] c_op_add    = 3'b010;
    localparam logic [2:0] c_op_sub    = 3'b011;
    localparam logic [2:0] c_op_bitrev = 3'b100;
    localparam logic [2:0] c_op_mul    = 3'b101;
    localparam logic [2:0] c_last_cnt  = 3'(RD_LAT);

    state_t              state_q, state_d;
    logic [2:0]          lat_op_q, lat_op_d;
    logic [ADDR_W-1:0]   lat_rd_q, lat_rd_d;
    logic [ADDR_W-1:0]   lat_rs1_q, lat_rs1_d;
    logic [ADDR_W-1:0]   lat_rs2_q, lat_rs2_d;
    logic [DATA_W-1:0]   lat_imm_q, lat_imm_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [ADDR_W-1:0]   res_rd_q, res_rd_d;
    logic                illegal_q, illegal_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lat_op_q   <= '0;
            lat_rd_q   <= '0;
            lat_rs1_q  <= '0;
            lat_rs2_q  <= '0;
            lat_imm_q  <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_op_q   <= lat_op_d;
            lat_rd_q   <= lat_rd_d;
            lat_rs1_q  <= lat_rs1_d;
            lat_rs2_q  <= lat_rs2_d;
            lat_imm_q  <= lat_imm_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_op_d   = lat_op_q;
        lat_rd_d   = lat_rd_q;
        lat_rs1_d  = lat_rs1_q;
        lat_rs2_d  = lat_rs2_q;
        lat_imm_d  = lat_imm_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        illegal_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // instr_ready is exactly "in IDLE", so instr_valid here is an accept
                if (instr_valid) begin
                    lat_op_d  = instr_op;
                    lat_rd_d  = instr_rd;
                    lat_rs1_d = instr_rs1;
                    lat_rs2_d = instr_rs2;
                    lat_imm_d = instr_imm;
                    case (instr_op)
                        c_op_nop:  state_d = S_IDLE;
                        c_op_load: state_d = S_LOAD_WR;
                        c_op_add, c_op_sub, c_op_bitrev, c_op_mul: begin
                            state_d = S_EXEC;
                            cnt_d   = '0;
                        end
                        default:   illegal_d = 1'b1;
                    endcase
                end
            end
            S_LOAD_WR: state_d = S_IDLE;
            S_EXEC: begin
                if (cnt_q == c_last_cnt) begin
                    res_data_d = aluresult_in;
                    res_rd_d   = lat_rd_q;
                    state_d    = WB_EN ? S_WB : S_RESP;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            S_WB:   state_d = S_RESP;
            S_RESP: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only from registered state and latched fields.
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        res_valid   = (state_q == S_RESP);
        res_data    = res_data_q;
        res_rd      = res_rd_q;
        illegal_op  = illegal_q;
        rs1         = '0;
        rs2         = '0;
        rd          = '0;
        wr_data     = '0;
        rd_wr_en    = 1'b0;
        rs1_rd_en   = 1'b0;
        rs2_rd_en   = 1'b0;
        Radd_en     = 1'b0;
        Rsub_en     = 1'b0;
        bitrev_en   = 1'b0;
        mul_en      = 1'b0;

        case (state_q)
            S_LOAD_WR: begin
                rd       = lat_rd_q;
                wr_data  = lat_imm_q;
                rd_wr_en = 1'b1;
            end
            S_EXEC: begin
                rs1       = lat_rs1_q;
                rs2       = lat_rs2_q;
                rs1_rd_en = 1'b1;
                rs2_rd_en = 1'b1;
                Radd_en   = (lat_op_q == c_op_add);
                Rsub_en   = (lat_op_q == c_op_sub);
                bitrev_en = (lat_op_q == c_op_bitrev);
                mul_en    = (lat_op_q == c_op_mul);
            end
            S_WB: begin
                rd       = lat_rd_q;
                wr_data  = res_data_q;
                rd_wr_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_lane_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_lane_issue_ctrl
// Description : Directed bench with a lane model and a timeline-based checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_lane_issue_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int LAT = 1;
    localparam bit WB  = 1'b1;

    logic          clk, rst;
    logic          instr_valid, instr_ready;
    logic [2:0]    instr_op;
    logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
    logic [DW-1:0] instr_imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] wr_data, aluresult_in, res_data;
    logic          rd_wr_en, rs1_rd_en, rs2_rd_en;
    logic          Radd_en, Rsub_en, bitrev_en, mul_en;
    logic          res_valid, res_ready, illegal_op;
    logic [AW-1:0] res_rd;

    simd_lane_issue_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .WB_EN(WB)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .wr_data(wr_data),
        .rd_wr_en(rd_wr_en), .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en),
        .Radd_en(Radd_en), .Rsub_en(Rsub_en), .bitrev_en(bitrev_en), .mul_en(mul_en),
        .aluresult_in(aluresult_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- lane: register file + one-cycle-latency ALU ----------------
    logic [DW-1:0] lregs [32] = '{default: '0};
    logic [DW-1:0] la = '0, lb = '0;
    logic [3:0]    lsel = '0;

    function automatic logic [DW-1:0] lane_rev(input logic [DW-1:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = a[DW-1-i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rd_wr_en === 1'b1) lregs[rd] <= wr_data;
        if (rs1_rd_en === 1'b1) begin
            la <= lregs[rs1];
            lb <= lregs[rs2];
        end
        lsel <= {Radd_en, Rsub_en, bitrev_en, mul_en};
    end

    always_comb begin
        case (lsel)
            4'b1000: aluresult_in = la + lb;
            4'b0100: aluresult_in = la - lb;
            4'b0010: aluresult_in = lane_rev(la);
            4'b0001: aluresult_in = DW'(la * lb);
            default: aluresult_in = '0;
        endcase
    end

    // ---------------- reference model: instruction timeline ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_ALU = 2, M_ONE = 3;
    int            cyc = 0;
    int            mode = M_IDLE;
    int            m_a = 0;
    logic          m_ill = 1'b0;
    logic [2:0]    m_op = '0;
    logic [AW-1:0] m_rd = '0, m_rs1 = '0, m_rs2 = '0, m_last_rd = '0;
    logic [DW-1:0] m_imm = '0, m_cur = '0, m_last = '0;
    logic [DW-1:0] mregs [32] = '{default: '0};

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            3'b010:  r = a + b;
            3'b011:  r = a - b;
            3'b100:  r = {<<{a}};
            3'b101:  r = DW'(a * b);
            default: r = '0;
        endcase
        return r;
    endfunction

    int   t_cur;
    logic e_ready, e_exec, e_wb, e_resp, e_load, e_ill;
    assign t_cur   = cyc - m_a;
    assign e_ready = (mode == M_IDLE) || (mode == M_ONE) || (mode == M_LOAD && t_cur >= 1);
    assign e_exec  = (mode == M_ALU) && (t_cur <= LAT);
    assign e_wb    = (mode == M_ALU) && WB && (t_cur == LAT + 1);
    assign e_resp  = (mode == M_ALU) && (t_cur >= LAT + 1 + int'(WB));
    assign e_load  = (mode == M_LOAD) && (t_cur == 0);
    assign e_ill   = (mode == M_ONE) && m_ill && (t_cur == 0);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= M_IDLE;
            m_ill     <= 1'b0;
            m_last    <= '0;
            m_last_rd <= '0;
        end else begin
            if (e_load) mregs[m_rd] <= m_imm;
            if (e_wb)   mregs[m_rd] <= m_cur;
            if (e_resp && res_ready) begin
                mode      <= M_IDLE;
                m_last    <= m_cur;
                m_last_rd <= m_rd;
            end
            if (e_ready && instr_valid) begin
                m_a   <= cyc + 1;
                m_op  <= instr_op;
                m_rd  <= instr_rd;
                m_rs1 <= instr_rs1;
                m_rs2 <= instr_rs2;
                m_imm <= instr_imm;
                m_cur <= ref_alu(instr_op, mregs[instr_rs1], mregs[instr_rs2]);
                m_ill <= (instr_op[2:1] == 2'b11);
                case (instr_op)
                    3'b001:                         mode <= M_LOAD;
                    3'b010, 3'b011, 3'b100, 3'b101: mode <= M_ALU;
                    default:                        mode <= M_ONE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_ready", instr_ready, e_ready);
            chk("rd_wr_en", rd_wr_en, e_load | e_wb);
            chk("rs1_rd_en", rs1_rd_en, e_exec);
            chk("rs2_rd_en", rs2_rd_en, e_exec);
            chk("Radd_en", Radd_en, e_exec && m_op == 3'b010);
            chk("Rsub_en", Rsub_en, e_exec && m_op == 3'b011);
            chk("bitrev_en", bitrev_en, e_exec && m_op == 3'b100);
            chk("mul_en", mul_en, e_exec && m_op == 3'b101);
            chk("res_valid", res_valid, e_resp);
            chk("illegal_op", illegal_op, e_ill);
            chk("onehot", ($countones({Radd_en, Rsub_en, bitrev_en, mul_en}) <= 1), 1);
            if (e_exec) begin
                chk("rs1", rs1, m_rs1);
                chk("rs2", rs2, m_rs2);
            end
            if (e_load) begin
                chk("load_rd", rd, m_rd);
                chk("load_wr_data", wr_data, m_imm);
            end
            if (e_wb) begin
                chk("wb_rd", rd, m_rd);
                chk("wb_wr_data", wr_data, m_cur);
            end
            if (!e_exec) begin
                chk("res_data", res_data, (mode == M_ALU && t_cur >= LAT + 1) ? m_cur : m_last);
                chk("res_rd", res_rd, (mode == M_ALU && t_cur >= LAT + 1) ? m_rd : m_last_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Returns at the falling edge of the first cycle after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [DW-1:0] imm);
        int w;
        @(negedge clk);
        instr_op = op; instr_rd = d; instr_rs1 = s1; instr_rs2 = s2; instr_imm = imm;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("issue_timeout", 0, 1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 1;
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("result_timeout", res_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, radd;
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_rd_wr_en", rd_wr_en, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_illegal", illegal_op, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // LOAD: single write cycle, no result handshake
        issue(3'b001, 5'd3, 5'd0, 5'd0, 16'h1234);
        chk("t1_rd", rd, 3);
        chk("t1_wr_data", wr_data, 16'h1234);
        chk("t1_wr_en", rd_wr_en, 1);
        @(negedge clk);
        chk("t1_wr_en_off", rd_wr_en, 0);
        chk("t1_no_res", res_valid, 0);

        // ADD with write-back, latency and result pinned
        issue(3'b001, 5'd1, 5'd0, 5'd0, 16'h0003);
        issue(3'b001, 5'd2, 5'd0, 5'd0, 16'h0004);
        issue(3'b010, 5'd5, 5'd1, 5'd2, 16'h0000);
        n = 1; radd = 0;
        while (!res_valid && n < 30) begin
            if (Radd_en) radd++;
            @(negedge clk);
            n++;
        end
        chk("t2_latency", n, 4);
        chk("t2_radd_cycles", radd, 2);
        chk("t2_res_data", res_data, 16'h0007);
        chk("t2_res_rd", res_rd, 5);
        chk("t2_lane_r5", lregs[5], 16'h0007);
        @(negedge clk);
        chk("t2_res_valid_drop", res_valid, 0);

        // Backpressure in RESP with ignored extra instructions
        res_ready = 1'b0;
        issue(3'b101, 5'd8, 5'd1, 5'd2, 16'h0000);
        wait_result(n);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_data", res_data, 16'h000C);
            chk("t3_busy", instr_ready, 0);
            instr_valid = (i < 3);
            instr_op = 3'b001; instr_rd = 5'd9; instr_imm = 16'hBEEF;
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid_drop", res_valid, 0);
        chk("t3_data_hold", res_data, 16'h000C);
        chk("t3_no_r9_write", lregs[9], 0);

        // NOP and illegal opcode
        issue(3'b000, 5'd4, 5'd0, 5'd0, 16'h5555);
        chk("nop_ready", instr_ready, 1);
        issue(3'b111, 5'd10, 5'd1, 5'd2, 16'h0000);
        chk("t4_illegal", illegal_op, 1);
        chk("t4_ready", instr_ready, 1);
        chk("t4_no_read", rs1_rd_en, 0);
        @(negedge clk);
        chk("t4_pulse_end", illegal_op, 0);

        // Asynchronous reset mid-EXEC
        issue(3'b010, 5'd11, 5'd1, 5'd2, 16'h0000);
        chk("t5_exec", Radd_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_radd_off", Radd_en, 0);
        chk("t5_read_off", rs1_rd_en, 0);
        chk("t5_ready", instr_ready, 1);
        chk("t5_no_write", rd_wr_en, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_r11_untouched", lregs[11], 0);
        issue(3'b010, 5'd12, 5'd1, 5'd2, 16'h0000);
        wait_result(n);
        chk("t5_latency", n, 4);
        chk("t5_res_data", res_data, 16'h0007);
        chk("t5_res_rd", res_rd, 12);

        // SUB then BITREV
        issue(3'b011, 5'd6, 5'd1, 5'd2, 16'h0000);
        wait_result(n);
        chk("t6_sub", res_data, 16'hFFFF);
        issue(3'b001, 5'd1, 5'd0, 5'd0, 16'h0001);
        issue(3'b100, 5'd7, 5'd1, 5'd2, 16'h0000);
        wait_result(n);
        chk("t6_bitrev", res_data, 16'h8000);
        chk("t6_bitrev_rd", res_rd, 7);
        repeat (3) @(negedge clk);
        chk("t6_lane_r7", lregs[7], 16'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
